// File: rtl/ann_pkg.sv
// Shared types and elaboration-time helpers for the serial MAC neuron.
// Used by the neuron top level and its activation/saturation stage.
package ann_pkg;

    typedef enum logic [1:0] {IDLE, ACC, BIAS, ACT} state_t;

    function automatic int dataWidth(input int featureWide);
        return featureWide + 16;
    endfunction

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic longint sat_signed(input longint value, input int width);
        longint maxVal;
        longint minVal;
        maxVal = (longint'(1) <<< (width - 1)) - 1;
        minVal = -(longint'(1) <<< (width - 1));
        if (value > maxVal) return maxVal;
        if (value < minVal) return minVal;
        return value;
    endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Sample stream into the neuron and result stream out of it.
// The upstream serializer drives the master side; the neuron is the slave.
interface neuron_mac_if #(
    parameter int DATA_W = 20
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] result;
    logic                     out_valid;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  result,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output result,
        output out_valid
    );

endinterface

// File: rtl/neuron_mac_act_sat.sv
// Output stage: drops the weight fraction bits, applies optional ReLU and clamps
// to the output width, registering the result with a one-cycle valid pulse.
module act_sat
    import ann_pkg::*;
#(
    parameter int ACC_W   = 41,
    parameter int DATA_W  = 20,
    parameter int FRAC_W  = 8,
    parameter int RELU_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_en,
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic signed [DATA_W-1:0] o_result,
    output logic                     o_valid
);

    logic signed [ACC_W-1:0]  w_shift;
    logic signed [ACC_W-1:0]  w_relu;
    logic signed [DATA_W-1:0] w_sat;
    logic signed [DATA_W-1:0] r_result;
    logic                     r_valid;

    // Arithmetic shift rounds toward -inf, matching floor of the fixed-point value.
    assign w_shift = i_acc >>> FRAC_W;
    assign w_relu  = ((RELU_EN != 0) && (w_shift < 0)) ? '0 : w_shift;
    assign w_sat   = DATA_W'(sat_signed(longint'(w_relu), DATA_W));

    // result is only updated on a completed inference; clear kills the pulse only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_valid  <= 1'b0;
        end else if (i_clear) begin
            r_valid  <= 1'b0;
        end else begin
            r_valid <= i_en;
            if (i_en) r_result <= w_sat;
        end
    end

    assign o_result = r_result;
    assign o_valid  = r_valid;

endmodule

// File: rtl/neuron_mac.sv
// Serial multiply-accumulate neuron: one weighted sample per accepted beat,
// then bias, activation and saturation back to the input sample width.
module neuron_mac
    import ann_pkg::*;
#(
    parameter int FEATURE_WIDE = 4,
    parameter int IN_NUM       = 12,
    parameter int WEIGHT_W     = 16,
    parameter int FRAC_W       = 8,
    parameter int RELU_EN      = 1,
    localparam int DATA_W      = dataWidth(FEATURE_WIDE)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clear,
    input  logic [IN_NUM*WEIGHT_W-1:0]   i_weights,
    input  logic signed [DATA_W-1:0]     i_bias,
    neuron_mac_if.slave                  bus
);

    localparam int ACC_W = DATA_W + WEIGHT_W + clog2(IN_NUM) + 1;
    localparam int CNT_W = (clog2(IN_NUM + 1) < 1) ? 1 : clog2(IN_NUM + 1);

    state_t                     r_state;
    state_t                     w_stateNext;
    logic [CNT_W-1:0]           r_cnt;
    logic signed [ACC_W-1:0]    r_acc;
    logic                       w_accept;
    logic                       w_inReady;
    logic                       w_actEn;
    logic signed [WEIGHT_W-1:0] w_weight;
    logic signed [DATA_W-1:0]   w_data;
    logic signed [ACC_W-1:0]    w_prod;
    logic signed [ACC_W-1:0]    w_biasExt;
    logic signed [DATA_W-1:0]   w_result;
    logic                       w_outValid;

    always_comb begin
        w_weight = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            if (r_cnt == CNT_W'(i)) w_weight = i_weights[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    assign w_data    = bus.in_data;
    assign w_prod    = ACC_W'(w_data) * ACC_W'(w_weight);
    assign w_biasExt = ACC_W'(i_bias) <<< FRAC_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_stateNext;
    end

    // Clear overrides everything, including a sample arriving in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_inReady   = 1'b0;
        w_actEn     = 1'b0;
        case (r_state)
            IDLE: begin
                w_inReady = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    if (IN_NUM == 1) w_stateNext = BIAS;
                    else             w_stateNext = ACC;
                end
            end
            ACC: begin
                w_inReady = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    if (r_cnt == CNT_W'(IN_NUM - 1)) w_stateNext = BIAS;
                end
            end
            BIAS: w_stateNext = ACT;
            ACT: begin
                w_actEn     = 1'b1;
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
        if (i_clear) begin
            w_stateNext = IDLE;
            w_accept    = 1'b0;
            w_actEn     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= (r_state == IDLE) ? w_prod : r_acc + w_prod;
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (r_state == BIAS) begin
            r_acc <= r_acc + w_biasExt;
        end else if (w_actEn) begin
            r_cnt <= '0;
        end
    end

    act_sat #(
        .ACC_W   (ACC_W),
        .DATA_W  (DATA_W),
        .FRAC_W  (FRAC_W),
        .RELU_EN (RELU_EN)
    ) u_actSat (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (i_clear),
        .i_en     (w_actEn),
        .i_acc    (r_acc),
        .o_result (w_result),
        .o_valid  (w_outValid)
    );

    assign bus.in_ready  = w_inReady;
    assign bus.result    = w_result;
    assign bus.out_valid = w_outValid;

endmodule
